// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 exception/interrupt controller.
// Holds the register addresses, the ExcCode values, the Status/Cause field
// positions and the exception-kind enum used by the arbiter.
// The optional timer is enabled with the CP0_TIMER_EN macro.
package cp0_pkg;

    // CP0 register addresses
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_UNI = 5'd10;
    localparam logic [4:0] EXCCODE_OVR = 5'd12;

    // Status field positions
    localparam int ST_IE   = 0;   // external interrupt enable
    localparam int ST_SYS  = 1;   // syscall enable
    localparam int ST_UNI  = 2;   // unimplemented-instruction enable
    localparam int ST_OVR  = 3;   // overflow enable
    localparam int ST_SAVE = 4;   // [7:4] saved copy of [3:0]
    localparam int ST_IM   = 8;   // per-line interrupt mask
    localparam int ST_TM   = 16;  // timer interrupt mask

    // Cause field positions
    localparam int CA_EXC  = 2;   // [6:2] ExcCode
    localparam int CA_IP   = 8;   // pending lines, read-only
    localparam int CA_TI   = 16;  // timer interrupt pending

    // Winner of the exception arbitration, highest priority first
    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_OVR  = 3'd1,
        KIND_UNI  = 3'd2,
        KIND_SYS  = 3'd3,
        KIND_INT  = 3'd4
    } exc_kind_e;

    // ExcCode recorded in Cause for a given winner
    function automatic logic [4:0] exc_code(input exc_kind_e k);
        logic [4:0] c;
        case (k)
            KIND_OVR: c = EXCCODE_OVR;
            KIND_UNI: c = EXCCODE_UNI;
            KIND_SYS: c = EXCCODE_SYS;
            default:  c = EXCCODE_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// cp0_prio_enc: lowest-index-first priority encoder over the masked
// pending interrupt vector. Produces a valid flag and a one-hot grant.
module cp0_prio_enc #(
    parameter int W = 4
) (
    input  logic [W-1:0] req_i,
    output logic         vld_o,
    output logic [W-1:0] gnt_o
);

    assign vld_o = |req_i;

    // Scan from the top down so the lowest set index is written last and wins
    always_comb begin
        gnt_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_intr_ctrl.sv
// cp0_intr_ctrl: coprocessor-0 Status/Cause/EPC, external interrupt latching
// and arbitration against synchronous exceptions for the pipelined core.
// Define CP0_TIMER_EN to add Count/Compare and the timer interrupt (Cause[16]).
module cp0_intr_ctrl
    import cp0_pkg::*;
#(
    parameter int          N_IRQ    = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0008
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    output logic [N_IRQ-1:0] irq_ack,
    input  logic             stall,
    input  logic             exc_sys,
    input  logic             exc_uni,
    input  logic             exc_ovr,
    input  logic             eret,
    input  logic             mtc0,
    input  logic             mfc0,
    input  logic [4:0]       rd,
    input  logic [31:0]      wdata,
    input  logic [31:0]      npc,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      exe_pc,
    output logic [31:0]      rdata,
    output logic             exc_take,
    output logic [31:0]      exc_vec,
    output logic [31:0]      epc_out,
    output logic             flush_if,
    output logic             flush_id
);

    // Architectural state
    logic [3:0]       st_en_q;     // Status[3:0]
    logic [3:0]       st_save_q;   // Status[7:4]
    logic [N_IRQ-1:0] im_q;        // Status IM
    logic [4:0]       excode_q;    // Cause ExcCode
    logic [N_IRQ-1:0] ip_q;        // Cause IP (sticky pending)
    logic [31:0]      epc_q;
    logic [N_IRQ-1:0] ack_q;
    logic [N_IRQ-1:0] ack_d;

    logic [N_IRQ-1:0] ip_msk;
    logic [N_IRQ-1:0] line_gnt;
    logic             line_vld;
    logic             ti_pend;
    logic             c_ovr, c_uni, c_sys, c_int;
    exc_kind_e        kind;
    logic             wr_ok, er_ok;
    logic [31:0]      status_rd, cause_rd;

    // Masked pending lines, lowest index is serviced first
    assign ip_msk = ip_q & im_q;

    cp0_prio_enc #(.W(N_IRQ)) u_prio_enc (
        .req_i (ip_msk),
        .vld_o (line_vld),
        .gnt_o (line_gnt)
    );

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, compare_q, count_inc;
    logic        ti_q, tm_q;

    assign count_inc = count_q + 32'd1;
    assign ti_pend   = ti_q & tm_q;
`else
    assign ti_pend   = 1'b0;
`endif

    // Candidates; int is held off during eret so the restored enables are seen first
    assign c_ovr = st_en_q[ST_OVR] & exc_ovr;
    assign c_uni = st_en_q[ST_UNI] & exc_uni;
    assign c_sys = st_en_q[ST_SYS] & exc_sys;
    assign c_int = st_en_q[ST_IE] & (line_vld | ti_pend) & ~eret;

    // Fixed-priority pick: ovr > uni > sys > int
    always_comb begin
        kind = KIND_NONE;
        if (c_ovr)      kind = KIND_OVR;
        else if (c_uni) kind = KIND_UNI;
        else if (c_sys) kind = KIND_SYS;
        else if (c_int) kind = KIND_INT;
    end

    assign exc_take = ~rst & ~stall & (kind != KIND_NONE);
    assign exc_vec  = VEC_BASE;
    assign epc_out  = epc_q;
    assign flush_if = exc_take;
    // ovr is in EXE so the ID instruction behind it dies too; sys/uni fault in ID itself
    assign flush_id = exc_take & ((kind == KIND_OVR) | (kind == KIND_INT));

    // Only an external line gets an ack; a timer win leaves ack_d at zero
    assign ack_d   = (exc_take && kind == KIND_INT) ? line_gnt : '0;
    assign irq_ack = ack_q;

    // A take suppresses any CP0 write or eret in the same cycle
    assign wr_ok = mtc0 & ~stall & ~exc_take;
    assign er_ok = eret & ~stall & ~exc_take;

    // Read views of Status and Cause; unimplemented bits read 0
    always_comb begin
        status_rd                   = '0;
        status_rd[3:0]              = st_en_q;
        status_rd[7:4]              = st_save_q;
        status_rd[ST_IM +: N_IRQ]   = im_q;
        cause_rd                    = '0;
        cause_rd[CA_EXC +: 5]       = excode_q;
        cause_rd[CA_IP +: N_IRQ]    = ip_q;
`ifdef CP0_TIMER_EN
        status_rd[ST_TM]            = tm_q;
        cause_rd[CA_TI]             = ti_q;
`endif
    end

    // mfc0 read mux, pre-edge values only
    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (rd)
                CP0_STATUS:  rdata = status_rd;
                CP0_CAUSE:   rdata = cause_rd;
                CP0_EPC:     rdata = epc_q;
`ifdef CP0_TIMER_EN
                CP0_COUNT:   rdata = count_q;
                CP0_COMPARE: rdata = compare_q;
`endif
                default:     rdata = '0;
            endcase
        end
    end

    // Status/Cause/EPC update: take, else eret, else mtc0
    always_ff @(posedge clk) begin
        if (rst) begin
            st_en_q   <= '0;
            st_save_q <= '0;
            im_q      <= '0;
            excode_q  <= '0;
            epc_q     <= '0;
        end else if (exc_take) begin
            excode_q  <= exc_code(kind);
            st_save_q <= st_en_q;
            st_en_q   <= '0;
            case (kind)
                KIND_OVR:           epc_q <= exe_pc;
                KIND_UNI, KIND_SYS: epc_q <= id_pc;
                default:            epc_q <= npc;
            endcase
        end else if (er_ok) begin
            st_en_q   <= st_save_q;
            st_save_q <= '0;
        end else if (wr_ok) begin
            case (rd)
                CP0_STATUS: begin
                    st_en_q   <= wdata[3:0];
                    st_save_q <= wdata[7:4];
                    im_q      <= wdata[ST_IM +: N_IRQ];
                end
                CP0_CAUSE: excode_q <= wdata[CA_EXC +: 5];
                CP0_EPC:   epc_q    <= wdata;
                default: ;
            endcase
        end
    end

    // Sticky pending latch and one-cycle ack, cleared together at the take edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ip_q  <= '0;
            ack_q <= '0;
        end else begin
            ip_q  <= (ip_q | irq) & ~ack_d;
            ack_q <= ack_d;
        end
    end

`ifdef CP0_TIMER_EN
    // Free-running Count, Compare match sets TI; writing Compare clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            ti_q      <= 1'b0;
            tm_q      <= 1'b0;
        end else begin
            count_q <= count_inc;
            if (count_inc == compare_q) ti_q <= 1'b1;
            if (wr_ok) begin
                case (rd)
                    CP0_COUNT:   count_q <= wdata;
                    CP0_COMPARE: begin
                        compare_q <= wdata;
                        ti_q      <= 1'b0;
                    end
                    CP0_STATUS:  tm_q <= wdata[ST_TM];
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// tb_cp0_intr_ctrl: directed, table-driven checks of cp0_intr_ctrl plus
// hand-written multi-cycle sequences (irq latency/ack, eret, stall, reset).
module tb_cp0_intr_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq, irq_ack;
    logic          stall, exc_sys, exc_uni, exc_ovr, eret, mtc0, mfc0;
    logic [4:0]    rd;
    logic [31:0]   wdata, npc, id_pc, exe_pc, rdata, exc_vec, epc_out;
    logic          exc_take, flush_if, flush_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_intr_ctrl #(.N_IRQ(N), .VEC_BASE(32'h0000_0008)) dut (
        .clk(clk), .rst(rst), .irq(irq), .irq_ack(irq_ack), .stall(stall),
        .exc_sys(exc_sys), .exc_uni(exc_uni), .exc_ovr(exc_ovr),
        .eret(eret), .mtc0(mtc0), .mfc0(mfc0), .rd(rd), .wdata(wdata),
        .npc(npc), .id_pc(id_pc), .exe_pc(exe_pc), .rdata(rdata),
        .exc_take(exc_take), .exc_vec(exc_vec), .epc_out(epc_out),
        .flush_if(flush_if), .flush_id(flush_id)
    );

    typedef struct {
        logic        stall, ovr, uni, sys, mfc0;
        logic [4:0]  rd;
        logic        take, fid;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic quiet();
        irq = '0; stall = 0; exc_sys = 0; exc_uni = 0; exc_ovr = 0;
        eret = 0; mtc0 = 0; mfc0 = 0; rd = '0; wdata = '0;
    endtask

    // Start a cycle: just after the rising edge, previous pulses removed
    task automatic go();
        @(posedge clk); #1;
        quiet();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        go(); mtc0 = 1; rd = a; wdata = d; smp();
    endtask

    task automatic rdchk(input logic [4:0] a, input logic [31:0] exp, input string nm);
        go(); mfc0 = 1; rd = a; smp();
        chk(nm, rdata, exp);
    endtask

    initial begin
        quiet();
        rst = 1; npc = 32'h40; id_pc = 32'h24; exe_pc = 32'h20;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        smp();
        chk("rst_take", 32'(exc_take), 0);
        chk("rst_ack", 32'(irq_ack), 0);
        rdchk(12, 32'h0, "rst_status");
        rdchk(13, 32'h0, "rst_cause");
        rdchk(14, 32'h0, "rst_epc");

        // Write masks: only implemented Status bits, only ExcCode in Cause
        wr(12, 32'hFFFF_FFFF);
`ifdef CP0_TIMER_EN
        rdchk(12, 32'h0001_0FFF, "status_wmask");
`else
        rdchk(12, 32'h0000_0FFF, "status_wmask");
`endif
        wr(13, 32'hFFFF_FFFF);
        rdchk(13, 32'h0000_007C, "cause_wmask");
        wr(12, 32'h0000_010F);

        // Combinational arbitration table; inputs removed before each edge
        vt[0] = '{1'b0,1'b0,1'b0,1'b0,1'b1,5'd12,1'b0,1'b0,32'h0000_010F};
        vt[1] = '{1'b0,1'b1,1'b0,1'b0,1'b1,5'd14,1'b1,1'b1,32'h0};
        vt[2] = '{1'b0,1'b0,1'b1,1'b0,1'b1,5'd13,1'b1,1'b0,32'h0000_007C};
        vt[3] = '{1'b0,1'b0,1'b0,1'b1,1'b0,5'd12,1'b1,1'b0,32'h0};
        vt[4] = '{1'b0,1'b1,1'b0,1'b1,1'b1,5'd5, 1'b1,1'b1,32'h0};
        vt[5] = '{1'b1,1'b1,1'b1,1'b1,1'b1,5'd31,1'b0,1'b0,32'h0};
        vt[6] = '{1'b0,1'b0,1'b1,1'b1,1'b1,5'd12,1'b1,1'b0,32'h0000_010F};
        vt[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,32'h0};
        for (int i = 0; i < 8; i++) begin
            go();
            stall = vt[i].stall; exc_ovr = vt[i].ovr; exc_uni = vt[i].uni;
            exc_sys = vt[i].sys; mfc0 = vt[i].mfc0; rd = vt[i].rd;
            smp();
            chk($sformatf("tbl%0d_take", i), 32'(exc_take), 32'(vt[i].take));
            chk($sformatf("tbl%0d_fif", i), 32'(flush_if), 32'(vt[i].take));
            chk($sformatf("tbl%0d_fid", i), 32'(flush_id), 32'(vt[i].fid));
            chk($sformatf("tbl%0d_rdata", i), rdata, vt[i].rdata);
            chk($sformatf("tbl%0d_vec", i), exc_vec, 32'h0000_0008);
            #1 quiet();
        end

        // One-cycle irq pulse: take one cycle later, ack the cycle after
        go(); irq = 4'b0001; smp();
        chk("irq_latency_no_take", 32'(exc_take), 0);
        go(); smp();
        chk("irq_take", 32'(exc_take), 1);
        chk("irq_flush_id", 32'(flush_id), 1);
        go(); smp();
        chk("irq_ack0", 32'(irq_ack), 32'h1);
        chk("irq_no_retake", 32'(exc_take), 0);
        go(); smp();
        chk("irq_ack_one_cycle", 32'(irq_ack), 0);
        rdchk(14, 32'h40, "irq_epc");
        rdchk(12, 32'h0000_01F0, "irq_status_saved");
        rdchk(13, 32'h0, "irq_cause");

        // eret restores enables; then ovr beats sys
        go(); eret = 1; smp();
        go(); exc_ovr = 1; exc_sys = 1; smp();
        chk("ovr_sys_take", 32'(exc_take), 1);
        chk("ovr_sys_fid", 32'(flush_id), 1);
        rdchk(13, 32'h0000_0030, "ovr_excode");
        rdchk(14, 32'h20, "ovr_epc");
        rdchk(12, 32'h0000_01F0, "ovr_status");

        // IM=0110, lines 1,2,3 pending: 1 then 2, line 3 stays masked
        wr(12, 32'h0000_060F);
        go(); irq = 4'b1110; smp();
        go(); smp();
        chk("im_take1", 32'(exc_take), 1);
        go(); smp();
        chk("im_ack1", 32'(irq_ack), 32'h2);
        rdchk(13, 32'h0000_0C00, "im_ip_after1");
        go(); eret = 1; smp();
        chk("im_eret_no_take", 32'(exc_take), 0);
        go(); smp();
        chk("im_take2", 32'(exc_take), 1);
        go(); smp();
        chk("im_ack2", 32'(irq_ack), 32'h4);
        go(); eret = 1; smp();
        go(); smp();
        chk("im_line3_masked", 32'(exc_take), 0);
        rdchk(13, 32'h0000_0800, "im_ip_line3");

        // Pending, enabled int is held off in the eret cycle only
        wr(12, 32'h0000_08F1);
        go(); eret = 1; smp();
        chk("eret_blocks_int", 32'(exc_take), 0);
        go(); smp();
        chk("int_after_eret", 32'(exc_take), 1);
        go(); smp();
        chk("ack_line3", 32'(irq_ack), 32'h8);
        rdchk(12, 32'h0000_08F0, "eret_status");

        // Stall blocks the take and the mtc0; later take suppresses mtc0
        go(); irq = 4'b0001; smp();
        wr(12, 32'h0000_0101);
        go(); stall = 1; mtc0 = 1; rd = 14; wdata = 32'h99; smp();
        chk("stall_no_take", 32'(exc_take), 0);
        go(); npc = 32'h50; mtc0 = 1; mfc0 = 1; rd = 14; wdata = 32'h77; smp();
        chk("take_after_stall", 32'(exc_take), 1);
        chk("epc_unchanged_by_stall", rdata, 32'h40);
        go(); smp();
        chk("stall_ack", 32'(irq_ack), 32'h1);
        rdchk(14, 32'h50, "take_suppresses_mtc0");

        // No take while rst is high; reset clears saved state
        wr(12, 32'h0000_010F);
        go(); rst = 1; exc_ovr = 1; smp();
        chk("rst_blocks_take", 32'(exc_take), 0);
        chk("rst_blocks_flush", 32'(flush_if), 0);
        go(); rst = 0;
        rdchk(12, 32'h0, "rst2_status");
        rdchk(14, 32'h0, "rst2_epc");

`ifdef CP0_TIMER_EN
        begin
            bit found = 0;
            logic [31:0] cnt_at = '0;
            wr(11, 32'd5);
            wr(9, 32'd0);
            wr(12, 32'h0001_0001);
            for (int k = 0; k < 20 && !found; k++) begin
                go(); mfc0 = 1; rd = 9; smp();
                if (exc_take) begin
                    found = 1;
                    cnt_at = rdata;
                end
            end
            chk("timer_take_seen", 32'(found), 1);
            chk("timer_count_at_take", cnt_at, 32'd5);
            rdchk(13, 32'h0001_0000, "timer_ti_set");
            wr(11, 32'd100);
            rdchk(13, 32'h0, "timer_ti_cleared");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
